fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one read per fetch to instruction memory,
// returns the fetched word with its address, and handles redirect/flush by
// draining any in-flight response before refetching from the new target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    output logic        done,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        done_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;

    logic [31:0] req_addr_d;
    logic [31:0] pc_inc_d;

    // Address of a request issued this edge: a flush target always wins over the stored pc.
    always_comb begin
        req_addr_d = flush ? flush_pc : pc_q;
        pc_inc_d   = pc_q + 32'd4;
    end

    // Fetch state machine with registered request, completion and instruction outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            done_q      <= 1'b0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 32'h0000_0000;
            inst_q      <= 32'h0000_0000;
            inst_pc_q   <= 32'h0000_0000;
        end else begin
            done_q     <= 1'b0;
            imem_req_q <= 1'b0;
            if (flush) begin
                pc_q <= flush_pc;
            end
            case (state_q)
                S_IDLE: begin
                    // A flush alone restarts fetching from its target.
                    if (flush || enable) begin
                        state_q     <= S_REQ;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= req_addr_d;
                    end
                end
                S_REQ: begin
                    // The request already left; a flush must wait for its response.
                    state_q <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (flush) begin
                        if (imem_valid) begin
                            // Response arrived together with the redirect: drop it, refetch now.
                            state_q     <= S_REQ;
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= flush_pc;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else if (imem_valid) begin
                        inst_q    <= imem_rdata;
                        inst_pc_q <= pc_q;
                        pc_q      <= pc_inc_d;
                        done_q    <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    // Swallow the stale response, then fetch from the latest target.
                    if (imem_valid) begin
                        state_q     <= S_REQ;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= req_addr_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done      = done_q;
    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign inst      = inst_q;
    assign inst_pc   = inst_pc_q;

    // A start pulse while a fetch is in progress is a controller error.
    a_enable_idle: assert property (@(posedge clk) disable iff (!rstn)
        enable |-> (state_q == S_IDLE));

    // Responses are only expected while one is outstanding.
    a_valid_expected: assert property (@(posedge clk) disable iff (!rstn)
        (imem_valid && !flush) |-> (state_q == S_WAIT || state_q == S_DRAIN));

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: instruction memory model with programmable
// latency, scoreboard queues for expected requests and completions, and a
// monitor that compares every request and completion as it appears.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        done;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .done       (done),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_pc    (inst_pc)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Scoreboard
    logic [31:0] exp_addr[$];
    logic [63:0] exp_done[$];
    logic [31:0] model_pc = 32'h0;

    // Memory model state
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];
    int lat = 1;
    int resp_cnt = 0;
    int resp_cyc = -1;
    int req_cyc = -1;
    int done_cyc = -1;
    int dones = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Instruction memory: answers each request lat cycles later, in order.
    initial begin
        pend_t p;
        forever begin
            @(negedge clk);
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            if (!rstn) begin
                pend.delete();
            end else begin
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(pend[0].addr);
                    resp_cnt++;
                    resp_cyc = cyc;
                    pend.delete(0);
                end
                if (imem_req) begin
                    p.addr = imem_addr;
                    p.due  = cyc + lat;
                    pend.push_back(p);
                    req_cyc = cyc;
                end
            end
        end
    end

    // Monitor: compares each request and each completion against the scoreboard.
    initial begin
        logic [31:0] ea;
        logic [63:0] ed;
        forever begin
            @(negedge clk);
            #1;
            if (rstn) begin
                if (imem_req) begin
                    if (exp_addr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL req_unexpected got=%h exp=none", imem_addr);
                    end else begin
                        ea = exp_addr.pop_front();
                        check("req_addr", imem_addr, ea);
                    end
                end
                if (done) begin
                    dones++;
                    done_cyc = cyc;
                    if (exp_done.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected got_pc=%h exp=none", inst_pc);
                    end else begin
                        ed = exp_done.pop_front();
                        check("done_inst", inst, ed[63:32]);
                        check("done_pc", inst_pc, ed[31:0]);
                    end
                end
            end
        end
    end

    task automatic wait_quiet();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_addr.size() != 0 || exp_done.size() != 0 || pend.size() != 0) && n < 300);
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL timeout pending_req=%0d pending_done=%0d exp=0", exp_addr.size(), exp_done.size());
            exp_addr.delete();
            exp_done.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        exp_addr.delete();
        exp_done.delete();
        model_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // One fetch; k<0: no flush, k=0: flush together with enable, k>0: flush k cycles after enable.
    task automatic do_op(input int k, input logic [31:0] tgt, input int l);
        logic [31:0] old_pc = model_pc;
        int base = resp_cnt;
        bit old_done = 1'b0;
        lat = l;
        enable = 1'b1;
        if (k == 0) begin
            flush = 1'b1;
            flush_pc = tgt;
            exp_addr.push_back(tgt);
            exp_done.push_back({mem_word(tgt), tgt});
            model_pc = tgt + 32'd4;
        end else begin
            exp_addr.push_back(old_pc);
        end
        if (k < 0) begin
            exp_done.push_back({mem_word(old_pc), old_pc});
            model_pc = old_pc + 32'd4;
        end
        @(negedge clk);
        enable = 1'b0;
        flush = 1'b0;
        for (int i = 1; i <= k; i++) begin
            // The old fetch survives only if its response came strictly before the flush.
            if (!old_done && resp_cnt > base && resp_cyc < cyc) begin
                old_done = 1'b1;
                exp_done.push_back({mem_word(old_pc), old_pc});
                model_pc = old_pc + 32'd4;
            end
            if (i == k) begin
                flush = 1'b1;
                flush_pc = tgt;
                exp_addr.push_back(tgt);
                exp_done.push_back({mem_word(tgt), tgt});
                model_pc = tgt + 32'd4;
            end
            @(negedge clk);
            flush = 1'b0;
        end
        wait_quiet();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cyc;
        int d0;
        logic [31:0] tgt;
        @(negedge clk);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // First fetch, latency 1: request one cycle after enable, done three cycles after.
        en_cyc = cyc;
        do_op(-1, 32'h0, 1);
        check("first_req_cycle", req_cyc - en_cyc, 32'd1);
        check("first_done_cycle", done_cyc - en_cyc, 32'd3);
        check("first_inst_held", inst, 32'h0000_0013);
        check("first_pc_held", inst_pc, 32'h0);

        // Back-to-back fetches from reset, latency 3.
        do_reset();
        for (int i = 0; i < 3; i++) do_op(-1, 32'h0, 3);
        check("b2b_inst_pc", inst_pc, 32'h8);

        // Flush in WAIT, stale response two cycles later.
        do_op(2, 32'h100, 3);
        check("flush_wait_pc", inst_pc, 32'h100);
        // Flush in the same cycle as the response.
        do_op(3, 32'h200, 2);
        check("flush_same_pc", inst_pc, 32'h200);
        // Flush in REQ.
        do_op(1, 32'h340, 2);
        // Flush from IDLE with enable, then wrap past the top of memory.
        do_op(0, 32'hFFFF_FFFC, 2);
        check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        do_op(-1, 32'h0, 1);
        check("wrap_next_pc", inst_pc, 32'h0);

        // Reset during WAIT: late response suppressed, no completion until a new enable.
        lat = 4;
        exp_addr.push_back(model_pc);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_req", {31'h0, imem_req}, 32'h0);
        check("midrst_addr", imem_addr, 32'h0);
        check("midrst_inst", inst, 32'h0);
        check("midrst_inst_pc", inst_pc, 32'h0);
        exp_addr.delete();
        exp_done.delete();
        model_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        d0 = dones;
        for (int i = 0; i < 8; i++) @(negedge clk);
        check("midrst_no_done", dones - d0, 32'd0);
        do_op(-1, 32'h0, 2);
        check("midrst_refetch_pc", inst_pc, 32'h0);

        // Randomized fetch/flush mix.
        for (int i = 0; i < 40; i++) begin
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFFC;
            do_op(int'($urandom_range(0, 7)) - 1, tgt, int'($urandom_range(1, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
